// File: rtl/core_pkg.sv
// Core-wide shared types: datapath width plus the instruction-memory arbiter's
// state, owner and in-flight record types.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic {ARB_NORM, ARB_LOCK} imem_arb_state_t;

    typedef enum logic {OWN_FETCH, OWN_LDR} imem_owner_t;

    typedef struct packed {
        logic              valid;
        imem_owner_t       owner;
        logic              squash;
        logic [XLEN-1:0]   addr0;
        logic [XLEN-1:0]   addr1;
    } imem_inflight_t;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating fetch-denial counter; hit flags that fetch has waited MAX cycles.
module imem_arb_starve_ctr #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == MAX_V);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single instruction-memory port between fetch and the loader
// and routes each read response back to its owner two cycles after grant.
module imem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_req,
    input  logic [XLEN-1:0]     fetch_addr0,
    input  logic [XLEN-1:0]     fetch_addr1,
    input  logic                fetch_flush,
    output logic                fetch_gnt,
    output logic                fetch_rvalid,
    output logic [2*XLEN-1:0]   fetch_raddr,
    output logic [2*XLEN-1:0]   fetch_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic                ldr_lock,
    input  logic [XLEN-1:0]     ldr_addr,
    input  logic [XLEN-1:0]     ldr_wdata,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [XLEN-1:0]     ldr_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr0,
    output logic [XLEN-1:0]     mem_addr1,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata0,
    input  logic [XLEN-1:0]     mem_rdata1,
    output logic                arb_locked,
    output logic                err_spurious
);

    imem_arb_state_t state;
    imem_inflight_t  rec;
    imem_inflight_t  new_rec;
    logic            fetch_elig;
    logic            norm_arb;
    logic            starve_hit;
    logic            read_gnt;
    logic            squash_now;

    assign fetch_elig = fetch_req && !fetch_flush;
    // Once ldr_lock drops, a LOCK cycle arbitrates exactly like NORM.
    assign norm_arb   = (state == ARB_NORM) || !ldr_lock;

    always_comb begin
        fetch_gnt = 1'b0;
        ldr_gnt   = 1'b0;
        if (reset_n) begin
            if (norm_arb) begin
                if (fetch_elig && starve_hit) begin
                    fetch_gnt = 1'b1;
                end else if (ldr_req) begin
                    ldr_gnt = 1'b1;
                end else if (fetch_elig) begin
                    fetch_gnt = 1'b1;
                end
            end else begin
                ldr_gnt = ldr_req;
            end
        end
    end

    always_comb begin
        mem_en    = fetch_gnt || ldr_gnt;
        mem_we    = 1'b0;
        mem_addr0 = '0;
        mem_addr1 = '0;
        mem_wdata = '0;
        if (fetch_gnt) begin
            mem_addr0 = fetch_addr0;
            mem_addr1 = fetch_addr1;
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr0 = ldr_addr;
            mem_addr1 = ldr_addr + XLEN'(4);
            mem_wdata = ldr_wdata;
        end
    end

    imem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (fetch_elig && !fetch_gnt),
        .clr     (!fetch_elig || fetch_gnt),
        .hit     (starve_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_NORM;
        end else begin
            case (state)
                ARB_NORM: if (ldr_gnt && ldr_lock) state <= ARB_LOCK;
                ARB_LOCK: if (!ldr_lock) state <= ARB_NORM;
                default:  state <= ARB_NORM;
            endcase
        end
    end

    assign arb_locked = (state == ARB_LOCK);

    assign read_gnt = fetch_gnt || (ldr_gnt && !ldr_we);
    // A flush arriving in the response cycle squashes just like a stored one.
    assign squash_now = rec.squash || fetch_flush;

    always_comb begin
        new_rec.valid  = 1'b1;
        new_rec.owner  = fetch_gnt ? OWN_FETCH : OWN_LDR;
        new_rec.squash = 1'b0;
        new_rec.addr0  = mem_addr0;
        new_rec.addr1  = mem_addr1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec          <= '0;
            fetch_rvalid <= 1'b0;
            fetch_raddr  <= '0;
            fetch_rdata  <= '0;
            ldr_rvalid   <= 1'b0;
            ldr_rdata    <= '0;
            err_spurious <= 1'b0;
        end else begin
            fetch_rvalid <= 1'b0;
            ldr_rvalid   <= 1'b0;
            if (mem_rvalid && rec.valid) begin
                if (rec.owner == OWN_LDR) begin
                    ldr_rvalid <= 1'b1;
                    ldr_rdata  <= mem_rdata0;
                end else if (!squash_now) begin
                    fetch_rvalid <= 1'b1;
                    fetch_rdata  <= {mem_rdata1, mem_rdata0};
                    fetch_raddr  <= {rec.addr1, rec.addr0};
                end
            end
            if (mem_rvalid && !rec.valid) begin
                err_spurious <= 1'b1;
            end
            // A new read grant in the response cycle replaces the consumed record.
            if (read_gnt) begin
                rec <= new_rec;
            end else if (mem_rvalid) begin
                rec <= '0;
            end else if (rec.valid && fetch_flush) begin
                rec.squash <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a one-cycle-latency memory model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req, fetch_flush, fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_addr0, fetch_addr1;
    logic [63:0] fetch_raddr, fetch_rdata;
    logic        ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we, mem_rvalid;
    logic [31:0] mem_addr0, mem_addr1, mem_wdata, mem_rdata0, mem_rdata1;
    logic        arb_locked, err_spurious;

    logic        mem_rv_q;
    logic        inject;
    int          errorCount = 0;
    int          checkCount = 0;

    always #5 clk = ~clk;

    // Memory answers every read exactly one cycle later; inject forces a stray response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mem_rv_q <= 1'b0;
        else          mem_rv_q <= mem_en && !mem_we;
    end
    assign mem_rvalid = mem_rv_q | inject;

    imem_arbiter #(.STARVE_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr0(fetch_addr0), .fetch_addr1(fetch_addr1),
        .fetch_flush(fetch_flush), .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .fetch_raddr(fetch_raddr), .fetch_rdata(fetch_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata0(mem_rdata0),
        .mem_rdata1(mem_rdata1), .arb_locked(arb_locked), .err_spurious(err_spurious)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic ff,
                                 input logic lr, input logic lw, input logic ll,
                                 input logic [31:0] la, input logic [31:0] lwd);
        fetch_req   = fr;
        fetch_addr0 = fa;
        fetch_addr1 = fa + 32'd4;
        fetch_flush = ff;
        ldr_req     = lr;
        ldr_we      = lw;
        ldr_lock    = ll;
        ldr_addr    = la;
        ldr_wdata   = lwd;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        inject = 1'b0;
        mem_rdata0 = '0;
        mem_rdata1 = '0;
        nextCycle();
        // Requests during reset must not be granted.
        applyStimulus(1, 32'h100, 0, 1, 0, 0, 32'h40, 0);
        checkOutput("rst_fetch_gnt", fetch_gnt, 0);
        checkOutput("rst_ldr_gnt", ldr_gnt, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_fetch_rvalid", fetch_rvalid, 0);
        checkOutput("rst_err", err_spurious, 0);
        idle();
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // Fetch-only read of 0x100.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_gnt", fetch_gnt, 1);
        checkOutput("f1_ldr_gnt", ldr_gnt, 0);
        checkOutput("f1_mem_en", mem_en, 1);
        checkOutput("f1_addr0", mem_addr0, 32'h100);
        checkOutput("f1_addr1", mem_addr1, 32'h104);
        nextCycle();
        idle();
        mem_rdata0 = 32'hAAAA0001;
        mem_rdata1 = 32'hAAAA0002;
        checkOutput("f1_rvalid_early", fetch_rvalid, 0);
        nextCycle();
        checkOutput("f1_rvalid", fetch_rvalid, 1);
        checkOutput("f1_rdata", fetch_rdata, 64'hAAAA0002_AAAA0001);
        checkOutput("f1_raddr", fetch_raddr, 64'h00000104_00000100);
        nextCycle();
        checkOutput("f1_rvalid_pulse", fetch_rvalid, 0);
        checkOutput("f1_rdata_hold", fetch_rdata, 64'hAAAA0002_AAAA0001);

        // Loader read beats simultaneous fetch; fetch wins next cycle.
        applyStimulus(1, 32'h200, 0, 1, 0, 0, 32'h40, 0);
        checkOutput("l2_ldr_gnt", ldr_gnt, 1);
        checkOutput("l2_fetch_gnt", fetch_gnt, 0);
        checkOutput("l2_addr0", mem_addr0, 32'h40);
        checkOutput("l2_addr1", mem_addr1, 32'h44);
        checkOutput("l2_we", mem_we, 0);
        nextCycle();
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        mem_rdata0 = 32'h12345678;
        mem_rdata1 = 32'hDEAD0000;
        checkOutput("l2_fetch_next", fetch_gnt, 1);
        checkOutput("l2_fetch_addr", mem_addr0, 32'h200);
        nextCycle();
        idle();
        mem_rdata0 = 32'h11110000;
        mem_rdata1 = 32'h22220000;
        checkOutput("l2_ldr_rvalid", ldr_rvalid, 1);
        checkOutput("l2_ldr_rdata", ldr_rdata, 32'h12345678);
        checkOutput("l2_no_fetch_rv", fetch_rvalid, 0);
        nextCycle();
        checkOutput("l2_fetch_rvalid", fetch_rvalid, 1);
        checkOutput("l2_fetch_rdata", fetch_rdata, 64'h22220000_11110000);
        checkOutput("l2_fetch_raddr", fetch_raddr, 64'h00000204_00000200);
        checkOutput("l2_ldr_pulse", ldr_rvalid, 0);

        // Continuous unlocked loader writes against continuous fetch.
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'h300, 0, 1, 1, 0, 32'h80, 32'hCAFE0000 + i);
            checkOutput($sformatf("s3_deny%0d", i), fetch_gnt, 0);
            checkOutput($sformatf("s3_ldr%0d", i), ldr_gnt, 1);
            nextCycle();
        end
        applyStimulus(1, 32'h300, 0, 1, 1, 0, 32'h80, 32'hCAFE0008);
        checkOutput("s3_forced_gnt", fetch_gnt, 1);
        checkOutput("s3_forced_ldr", ldr_gnt, 0);
        checkOutput("s3_forced_addr", mem_addr0, 32'h300);
        checkOutput("s3_forced_we", mem_we, 0);
        nextCycle();
        applyStimulus(1, 32'h300, 0, 1, 1, 0, 32'h80, 32'hCAFE0009);
        mem_rdata0 = 32'h33330000;
        mem_rdata1 = 32'h33330004;
        checkOutput("s3_ldr_resume", ldr_gnt, 1);
        checkOutput("s3_fetch_after", fetch_gnt, 0);
        checkOutput("s3_wdata", mem_wdata, 32'hCAFE0009);
        checkOutput("s3_we", mem_we, 1);
        nextCycle();
        idle();
        checkOutput("s3_rvalid", fetch_rvalid, 1);
        checkOutput("s3_raddr", fetch_raddr, 64'h00000304_00000300);
        nextCycle();

        // Locked 16-word boot burst with fetch held.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 32'h400, 0, 1, 1, 1, 32'(i * 4), 32'(i));
            checkOutput($sformatf("k4_ldr%0d", i), ldr_gnt, 1);
            checkOutput($sformatf("k4_nofetch%0d", i), fetch_gnt, 0);
            checkOutput($sformatf("k4_addr%0d", i), mem_addr0, 32'(i * 4));
            checkOutput($sformatf("k4_ldr_rv%0d", i), ldr_rvalid, 0);
            checkOutput($sformatf("k4_locked%0d", i), arb_locked, (i == 0) ? 1'b0 : 1'b1);
            nextCycle();
        end
        applyStimulus(1, 32'h400, 0, 1, 1, 0, 32'h40, 32'h99);
        checkOutput("k4_release_fetch", fetch_gnt, 1);
        checkOutput("k4_release_ldr", ldr_gnt, 0);
        checkOutput("k4_release_locked", arb_locked, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 0, 32'h44, 32'h9A);
        checkOutput("k4_norm", arb_locked, 0);
        checkOutput("k4_ldr_after", ldr_gnt, 1);
        nextCycle();
        idle();
        nextCycle();

        // Flush after grant squashes the response; flush also blocks fetch.
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
        checkOutput("q5_gnt", fetch_gnt, 1);
        nextCycle();
        applyStimulus(1, 32'h508, 1, 0, 0, 0, 0, 0);
        checkOutput("q5_flush_gnt", fetch_gnt, 0);
        checkOutput("q5_flush_en", mem_en, 0);
        nextCycle();
        idle();
        checkOutput("q5_squashed", fetch_rvalid, 0);
        nextCycle();
        checkOutput("q5_squashed2", fetch_rvalid, 0);

        // Flush in the rvalid cycle itself still sees the pulse.
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0);
        nextCycle();
        idle();
        mem_rdata0 = 32'h66660000;
        mem_rdata1 = 32'h66660004;
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("q5_late_flush_rv", fetch_rvalid, 1);
        checkOutput("q5_late_rdata", fetch_rdata, 64'h66660004_66660000);
        nextCycle();
        idle();

        // Stray memory response with nothing in flight.
        checkOutput("e6_err_clear", err_spurious, 0);
        inject = 1'b1;
        nextCycle();
        inject = 1'b0;
        checkOutput("e6_err_set", err_spurious, 1);
        checkOutput("e6_no_fetch_rv", fetch_rvalid, 0);
        checkOutput("e6_no_ldr_rv", ldr_rvalid, 0);
        nextCycle();
        nextCycle();
        checkOutput("e6_err_sticky", err_spurious, 1);

        // Reset between grant and response wipes everything.
        applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 0);
        checkOutput("r7_gnt", fetch_gnt, 1);
        nextCycle();
        idle();
        reset_n = 1'b0;
        #2;
        checkOutput("r7_fetch_rv", fetch_rvalid, 0);
        checkOutput("r7_ldr_rv", ldr_rvalid, 0);
        checkOutput("r7_fetch_rdata", fetch_rdata, 0);
        checkOutput("r7_fetch_raddr", fetch_raddr, 0);
        checkOutput("r7_ldr_rdata", ldr_rdata, 0);
        checkOutput("r7_err", err_spurious, 0);
        checkOutput("r7_mem_en", mem_en, 0);
        reset_n = 1'b1;
        nextCycle();
        checkOutput("r7_no_rv", fetch_rvalid, 0);
        checkOutput("r7_no_err", err_spurious, 0);
        nextCycle();
        checkOutput("r7_no_rv2", fetch_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single instruction-memory port between the two-wide fetch unit and the program loader/debug requester, which reads and writes single words. Each cycle it arbitrates, drives the memory request, and records who owns the in-flight request. One cycle later it routes the response back to that owner. It supports a locked loader burst for boot-time image writes, starvation protection for fetch, and squashing of fetch responses on redirect.

Parameters:
XLEN, 32, data/address width (from core_pkg)
STARVE_MAX, 8, consecutive fetch denials before fetch is forced to win (NORM state only)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch requests a two-word read
fetch_addr0  in  XLEN  first word address, word aligned
fetch_addr1  in  XLEN  second word address (fetch_addr0+4)
fetch_flush  in  1  redirect: deny and squash fetch traffic
fetch_gnt  out  1  fetch request accepted this cycle (combinational)
fetch_rvalid  out  1  one-cycle pulse, fetch response valid
fetch_raddr  out  2xXLEN  addresses of the returned pair
fetch_rdata  out  2xXLEN  returned instruction pair
ldr_req  in  1  loader request
ldr_we  in  1  1=write, 0=read
ldr_lock  in  1  hold port exclusively while high
ldr_addr  in  XLEN  word address
ldr_wdata  in  XLEN  write data
ldr_gnt  out  1  loader request accepted this cycle (combinational)
ldr_rvalid  out  1  one-cycle pulse, loader read data valid
ldr_rdata  out  XLEN  read data
mem_en  out  1  memory request strobe
mem_we  out  1  memory write
mem_addr0  out  XLEN  port address 0
mem_addr1  out  XLEN  port address 1 (fetch only, else addr0+4)
mem_wdata  out  XLEN  write data
mem_rvalid  in  1  read response, exactly 1 cycle after mem_en&&!mem_we
mem_rdata0  in  XLEN  data at addr0
mem_rdata1  in  XLEN  data at addr1
arb_locked  out  1  FSM in LOCK
err_spurious  out  1  sticky: mem_rvalid with no read in flight

Behaviour:
- Reset (reset_n low, async): FSM=NORM, starve counter=0, in-flight record cleared.
- Reset values: fetch_rvalid, ldr_rvalid, fetch_rdata, fetch_raddr, ldr_rdata, err_spurious all 0.
- Combinational outputs while reset_n is low: gnt and mem_en forced 0.
- At most one grant per cycle.
- mem_en=fetch_gnt|ldr_gnt. The mem_* fields are muxed from the granted requester, or are 0 when there is no grant.
- FSM NORM:
  - fetch_flush=1: fetch is ineligible.
  - Else if starve_cnt==STARVE_MAX and fetch_req: fetch wins.
  - Else loader wins over fetch.
  - A loader grant with ldr_lock=1 moves the FSM to LOCK next cycle.
- FSM LOCK: only the loader may be granted, and starvation is ignored. The first cycle with ldr_lock=0 arbitrates as NORM, and the FSM returns to NORM.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle with fetch_req && !fetch_flush && !fetch_gnt.
  - Clears on fetch_gnt, or on any cycle where fetch_req=0 or fetch_flush=1.
- In-flight record, set on any read grant: {valid, owner, squash, addr0, addr1}. Writes create no record.
  - A new grant in the response cycle overwrites the record; back-to-back reads are legal with one per cycle.
- squash bit: set when fetch_flush is high in the grant cycle+1. An in-flight fetch record with squash set drops its response.
- Response path: when mem_rvalid arrives with a valid record, the data is registered to the owner.
  - Owner output rvalid pulses in the following cycle, so total latency is grant to rvalid = 2 cycles.
  - Data and addr outputs hold until the next response.
  - A flush in the rvalid cycle itself does not suppress the pulse; decode discards it.
- Loader reads: ldr_rdata takes mem_rdata0. Loader writes never produce ldr_rvalid.
- mem_rvalid with no valid record: ignored, and err_spurious is set until reset.
- Addresses pass through unchanged. Misaligned addresses are the requester's responsibility.

Decomposition:
- core_pkg additions: XLEN (existing), typedef enum logic {ARB_NORM, ARB_LOCK} imem_arb_state_t, typedef enum logic {OWN_FETCH, OWN_LDR} imem_owner_t, struct imem_inflight_t.
- Sub-module imem_arb_starve_ctr: saturating counter with inc/clr inputs and a hit output.

Test Plan:
- Fetch only, addr0=0x100: fetch_gnt=1 same cycle, mem_addr0/1=0x100/0x104; memory returns 0xAAAA0001/0xAAAA0002 at +1 → fetch_rvalid at +2 with that data and raddr 0x100/0x104.
- Loader read of 0x40 and fetch request in the same cycle (NORM): ldr_gnt=1, fetch_gnt=0, mem_addr0=0x40; ldr_rvalid at +2 with mem_rdata0; fetch is granted next cycle.
- Loader unlocked continuous plus fetch continuous, STARVE_MAX=8: fetch is denied 8 cycles, granted on the 9th, counter returns to 0, and the loader resumes winning.
- ldr_lock=1 with 16 writes to 0x0..0x3C while fetch_req is held:
  - During the burst: arb_locked=1, no fetch_gnt, no ldr_rvalid, counter saturated at 8.
  - After ldr_lock drops: fetch is granted in that cycle even with ldr_req=1.
- Fetch granted at N, fetch_flush at N+1 → no fetch_rvalid at N+2; fetch_flush with fetch_req and no loader request → fetch_gnt=0, mem_en=0.
- mem_rvalid injected with nothing in flight → err_spurious=1, sticky; reset_n pulsed low between grant and response → all outputs 0, no rvalid afterwards.
